// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one burst-oriented memory read channel among NUM_REQ requesters.
// One burst outstanding at a time; beats are routed to the owner and the burst length is checked.
module mem_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4,
    parameter int ID_WIDTH   = 4,
    localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_arvalid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_arlen,
    input  logic [NUM_REQ*ID_WIDTH-1:0]   req_arid,
    output logic [NUM_REQ-1:0]            req_arready,
    output logic [NUM_REQ-1:0]            req_rvalid,
    input  logic [NUM_REQ-1:0]            req_rready,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic                          req_rlast,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    output logic [ADDR_WIDTH-1:0]         m_araddr,
    output logic [LEN_WIDTH-1:0]          m_arlen,
    output logic [ID_WIDTH-1:0]           m_arid,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic                          m_rlast,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy,
    output logic                          len_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [LEN_WIDTH-1:0] BEAT_MAX = {LEN_WIDTH{1'b1}};
    localparam logic [GW-1:0]        LAST_IDX = GW'(NUM_REQ - 1);

    state_t                state_r;
    logic [GW-1:0]         rr_ptr_r;
    logic [GW-1:0]         grant_id_r;
    logic [LEN_WIDTH-1:0]  len_r;
    logic [LEN_WIDTH-1:0]  beat_cnt_r;
    logic                  len_err_r;

    logic [GW-1:0]         pick_s;
    logic [GW-1:0]         cand_s;
    logic                  any_req_s;
    logic [LEN_WIDTH-1:0]  pick_len_s;
    logic                  beat_fire_s;

    // Round-robin pick: scanning downward lets the candidate closest to rr_ptr win last.
    always_comb begin
        pick_s = '0;
        cand_s = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_s = GW'((int'(rr_ptr_r) + k) % NUM_REQ);
            pick_s = req_arvalid[cand_s] ? cand_s : pick_s;
        end
    end

    // Request presence and the burst length of the winning requester.
    always_comb begin
        any_req_s  = |req_arvalid;
        pick_len_s = req_arlen[int'(pick_s)*LEN_WIDTH +: LEN_WIDTH];
    end

    // Channel muxing; everything is forced to zero while reset is asserted.
    always_comb begin
        req_arready = '0;
        req_rvalid  = '0;
        req_rdata   = '0;
        req_rlast   = 1'b0;
        m_arvalid   = 1'b0;
        m_araddr    = '0;
        m_arlen     = '0;
        m_arid      = '0;
        m_rready    = 1'b0;
        if (rst) begin
            m_rready = 1'b0;
        end else begin
            case (state_r)
                ADDR: begin
                    m_arvalid               = 1'b1;
                    m_araddr                = req_araddr[int'(grant_id_r)*ADDR_WIDTH +: ADDR_WIDTH];
                    m_arlen                 = req_arlen[int'(grant_id_r)*LEN_WIDTH +: LEN_WIDTH];
                    m_arid                  = req_arid[int'(grant_id_r)*ID_WIDTH +: ID_WIDTH];
                    req_arready[grant_id_r] = m_arready;
                end
                DATA: begin
                    req_rvalid[grant_id_r] = m_rvalid;
                    m_rready               = req_rready[grant_id_r];
                    req_rdata              = m_rdata;
                    req_rlast              = m_rlast;
                end
                default: begin
                    m_arvalid = 1'b0;
                end
            endcase
        end
    end

    // A beat moves only when the memory offers it and the owner accepts it.
    always_comb begin
        beat_fire_s = (state_r == DATA) && m_rvalid && m_rready;
    end

    // Burst sequencing, round-robin pointer and sticky length-error tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            rr_ptr_r   <= '0;
            grant_id_r <= '0;
            len_r      <= '0;
            beat_cnt_r <= '0;
            len_err_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        grant_id_r <= pick_s;
                        len_r      <= pick_len_s;
                        state_r    <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_arready) begin
                        beat_cnt_r <= '0;
                        rr_ptr_r   <= (grant_id_r == LAST_IDX) ? '0 : grant_id_r + GW'(1);
                        state_r    <= DATA;
                    end
                end
                DATA: begin
                    if (beat_fire_s) begin
                        if (beat_cnt_r != BEAT_MAX) begin
                            beat_cnt_r <= beat_cnt_r + LEN_WIDTH'(1);
                        end
                        if (m_rlast) begin
                            if (beat_cnt_r != len_r) begin
                                len_err_r <= 1'b1;
                            end
                            state_r <= IDLE;
                        end else if (beat_cnt_r >= len_r) begin
                            // Expected last beat already passed without rlast.
                            len_err_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign grant_id = grant_id_r;
    assign busy     = (state_r != IDLE);
    assign len_err  = len_err_r;

    mem_read_arbiter_chk #(
        .NUM_REQ (NUM_REQ)
    ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .req_arready (req_arready),
        .req_rvalid  (req_rvalid),
        .m_arvalid   (m_arvalid),
        .m_rready    (m_rready),
        .m_rvalid    (m_rvalid),
        .busy        (busy)
    );

endmodule

// Structural invariants of the arbiter outputs.
module mem_read_arbiter_chk #(
    parameter int NUM_REQ = 4
) (
    input logic               clk,
    input logic               rst,
    input logic [NUM_REQ-1:0] req_arready,
    input logic [NUM_REQ-1:0] req_rvalid,
    input logic               m_arvalid,
    input logic               m_rready,
    input logic               m_rvalid,
    input logic               busy
);

    a_arready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_arready));
    a_rvalid_onehot:  assert property (@(posedge clk) disable iff (rst) $onehot0(req_rvalid));
    a_arvalid_busy:   assert property (@(posedge clk) disable iff (rst) m_arvalid |-> busy);
    a_rready_busy:    assert property (@(posedge clk) disable iff (rst) m_rready |-> busy);
    a_rvalid_src:     assert property (@(posedge clk) disable iff (rst) (|req_rvalid) |-> m_rvalid);

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Table-driven bench for mem_read_arbiter: bursts are described by step records; routed beats
// are checked against a scoreboard filled as the memory side drives them.
module tb_mem_read_arbiter;

    localparam int NR = 4;
    localparam int AW = 26;
    localparam int DW = 32;
    localparam int LW = 4;
    localparam int IW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_arvalid = '0;
    logic [NR*AW-1:0]  req_araddr  = '0;
    logic [NR*LW-1:0]  req_arlen   = '0;
    logic [NR*IW-1:0]  req_arid    = '0;
    logic [NR-1:0]     req_arready;
    logic [NR-1:0]     req_rvalid;
    logic [NR-1:0]     req_rready  = '1;
    logic [DW-1:0]     req_rdata;
    logic              req_rlast;
    logic              m_arvalid;
    logic              m_arready   = 1'b0;
    logic [AW-1:0]     m_araddr;
    logic [LW-1:0]     m_arlen;
    logic [IW-1:0]     m_arid;
    logic              m_rvalid    = 1'b0;
    logic              m_rready;
    logic [DW-1:0]     m_rdata     = '0;
    logic              m_rlast     = 1'b0;
    logic [1:0]        grant_id;
    logic              busy;
    logic              len_err;

    always #5 clk = ~clk;

    mem_read_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .ID_WIDTH(IW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arlen(req_arlen),
        .req_arid(req_arid), .req_arready(req_arready), .req_rvalid(req_rvalid),
        .req_rready(req_rready), .req_rdata(req_rdata), .req_rlast(req_rlast),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arid(m_arid), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rdata(m_rdata), .m_rlast(m_rlast), .grant_id(grant_id), .busy(busy),
        .len_err(len_err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int len_of [NR];

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;
    beat_t sb_q [$];

    typedef struct {
        bit         rst_before;
        logic [3:0] raise;
        int         set_len;
        int         exp_grant;
        int         rlast_at;
        bit         stall;
        bit         keep;
        logic       exp_err;
        int         exp_lat;
    } step_t;
    step_t steps [16];

    function automatic logic [AW-1:0] exp_addr(input int i);
        return AW'(32'h000A_BC00 + (i << 16));
    endfunction

    function automatic logic [IW-1:0] exp_id(input int i);
        return IW'(i + 9);
    endfunction

    function automatic logic [DW-1:0] beat_data(input int si, input int b);
        return {8'hD5, 8'h00, 8'(si), 8'(b)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req_arvalid = '0; m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
        req_rready = '1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_len_err", len_err, 0);
        check("rst_m_arvalid", m_arvalid, 0);
        check("rst_arready", req_arready, 0);
        check("rst_rvalid", req_rvalid, 0);
        check("rst_m_rready", m_rready, 0);
    endtask

    task automatic run_burst(input step_t s, input int si);
        int         waited;
        int         b;
        int         pushed;
        int         cycles;
        bit         stalled;
        logic [3:0] oh;
        beat_t      e;
        oh = 4'(1 << s.exp_grant);
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++) begin
            if (s.raise[i]) begin
                req_arvalid[i] = 1'b1;
                req_arlen[i*LW +: LW] = LW'(s.set_len);
                len_of[i] = s.set_len;
            end
        end
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!m_arvalid && waited < 20);
        check($sformatf("s%0d_arvalid_wait", si), m_arvalid, 1);
        if (!m_arvalid) return;
        if (s.exp_lat != 0) check($sformatf("s%0d_ar_latency", si), waited, s.exp_lat);
        check($sformatf("s%0d_grant", si), grant_id, s.exp_grant);
        check($sformatf("s%0d_araddr", si), m_araddr, exp_addr(s.exp_grant));
        check($sformatf("s%0d_arlen", si), m_arlen, len_of[s.exp_grant]);
        check($sformatf("s%0d_arid", si), m_arid, exp_id(s.exp_grant));
        m_arready = 1'b1;
        #1;
        check($sformatf("s%0d_arready", si), req_arready, oh);
        @(posedge clk); #1;
        m_arready = 1'b0;
        if (!s.keep) req_arvalid[s.exp_grant] = 1'b0;
        b = 0; pushed = -1; cycles = 0; stalled = 1'b0;
        while (b <= s.rlast_at && cycles < 64) begin
            m_rvalid   = 1'b1;
            m_rdata    = beat_data(si, b);
            m_rlast    = (b == s.rlast_at);
            req_rready = '1;
            if (s.stall && b == 1 && !stalled) begin
                req_rready = ~oh;
                stalled    = 1'b1;
            end
            if (b != pushed) begin
                sb_q.push_back('{beat_data(si, b), (b == s.rlast_at)});
                pushed = b;
            end
            @(negedge clk);
            check($sformatf("s%0d_rvalid_route", si), req_rvalid, oh);
            check($sformatf("s%0d_m_rready", si), m_rready, req_rready[s.exp_grant]);
            if (req_rready[s.exp_grant]) begin
                e = sb_q.pop_front();
                check($sformatf("s%0d_rdata_b%0d", si, b), req_rdata, e.data);
                check($sformatf("s%0d_rlast_b%0d", si, b), req_rlast, e.last);
                b++;
            end
            @(posedge clk); #1;
            cycles++;
        end
        m_rvalid = 1'b0; m_rlast = 1'b0; req_rready = '1;
        @(negedge clk);
        check($sformatf("s%0d_busy_after", si), busy, 0);
        check($sformatf("s%0d_len_err", si), len_err, s.exp_err);
        check($sformatf("s%0d_sb_empty", si), sb_q.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step_t s6;
        int    waited;
        //          rst   raise    len grant rlast stall keep err  lat
        steps[0]  = '{1'b1, 4'b0001, 3, 0, 3, 1'b0, 1'b0, 1'b0, 2};
        steps[1]  = '{1'b1, 4'b1111, 0, 0, 0, 1'b0, 1'b0, 1'b0, 2};
        steps[2]  = '{1'b0, 4'b0000, 0, 1, 0, 1'b0, 1'b0, 1'b0, 0};
        steps[3]  = '{1'b0, 4'b0000, 0, 2, 0, 1'b0, 1'b0, 1'b0, 0};
        steps[4]  = '{1'b0, 4'b0000, 0, 3, 0, 1'b0, 1'b0, 1'b0, 0};
        steps[5]  = '{1'b0, 4'b0011, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0};
        steps[6]  = '{1'b0, 4'b0000, 0, 1, 0, 1'b0, 1'b0, 1'b0, 0};
        steps[7]  = '{1'b0, 4'b1010, 1, 3, 1, 1'b0, 1'b1, 1'b0, 0};
        steps[8]  = '{1'b0, 4'b0000, 1, 1, 1, 1'b0, 1'b1, 1'b0, 0};
        steps[9]  = '{1'b0, 4'b0000, 1, 3, 1, 1'b0, 1'b1, 1'b0, 0};
        steps[10] = '{1'b0, 4'b0000, 1, 1, 1, 1'b0, 1'b0, 1'b0, 0};
        steps[11] = '{1'b0, 4'b0000, 1, 3, 1, 1'b0, 1'b0, 1'b0, 0};
        steps[12] = '{1'b0, 4'b0100, 7, 2, 7, 1'b1, 1'b0, 1'b0, 0};
        steps[13] = '{1'b0, 4'b0001, 3, 0, 2, 1'b0, 1'b0, 1'b1, 0};
        steps[14] = '{1'b0, 4'b0010, 0, 1, 0, 1'b0, 1'b0, 1'b1, 0};
        steps[15] = '{1'b1, 4'b0001, 0, 0, 1, 1'b0, 1'b0, 1'b1, 2};

        for (int i = 0; i < NR; i++) begin
            req_araddr[i*AW +: AW] = exp_addr(i);
            req_arid[i*IW +: IW]   = exp_id(i);
            len_of[i] = 0;
        end

        for (int i = 0; i < 16; i++) begin
            if (steps[i].rst_before) do_reset();
            run_burst(steps[i], i);
        end

        // Reset in the middle of a data burst.
        do_reset();
        @(posedge clk); #1;
        req_arvalid[1] = 1'b1;
        req_arlen[1*LW +: LW] = LW'(3);
        len_of[1] = 3;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!m_arvalid && waited < 20);
        check("r6_arvalid_wait", m_arvalid, 1);
        check("r6_grant", grant_id, 1);
        m_arready = 1'b1;
        @(posedge clk); #1;
        m_arready = 1'b0;
        req_arvalid[1] = 1'b0;
        for (int b = 0; b < 2; b++) begin
            m_rvalid = 1'b1; m_rdata = beat_data(99, b); m_rlast = 1'b0;
            @(negedge clk);
            check("r6_pre_rvalid", req_rvalid, 4'b0010);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        m_rdata = beat_data(99, 2);
        #1;
        check("r6_rst_no_rvalid", req_rvalid, 0);
        check("r6_rst_no_rready", m_rready, 0);
        check("r6_rst_no_rdata", req_rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0; m_rvalid = 1'b0;
        @(negedge clk);
        check("r6_busy", busy, 0);
        check("r6_m_arvalid", m_arvalid, 0);
        check("r6_rvalid", req_rvalid, 0);
        check("r6_grant_zero", grant_id, 0);
        check("r6_len_err", len_err, 0);
        // rr_ptr back at 0: with req1 and req3 pending, req1 must win.
        s6 = '{1'b0, 4'b1010, 0, 1, 0, 1'b0, 1'b0, 1'b0, 2};
        run_burst(s6, 16);
        s6 = '{1'b0, 4'b0000, 0, 3, 0, 1'b0, 1'b0, 1'b0, 0};
        run_burst(s6, 17);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
